// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - sequencer-side bundle: IR/status/halt in, control word and step state out
interface control_sequencer_if #(
  parameter int CB_WIDTH = 33
);
  logic                hlt;
  logic [15:0]         instr;
  logic [3:0]          status;
  logic [CB_WIDTH-1:0] control_bus;
  logic [3:0]          T;
  logic                halted;

  modport master (
    output hlt, instr, status,
    input  control_bus, T, halted
  );

  modport slave (
    input  hlt, instr, status,
    output control_bus, T, halted
  );
endinterface

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - fetch/execute microsequencer driving the datapath control word
module control_sequencer #(
  parameter int CB_WIDTH = 33,
  parameter int ZERO_BIT = 1
) (
  input  logic               clk,
  input  logic               reset,
  control_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] t_q, t_nxt;
  logic       seen_q, seen_nxt;

  logic [7:0] op;
  logic [7:0] opd;
  logic       is_jmp, is_jz, is_hlt, two_step;
  logic       unused_bits;

  logic [4:0] alu, mid, sid;
  logic [1:0] amid;
  logic       pc_inr, mid_en, sid_en, amid_en;
  logic [CB_WIDTH-1:0] cb;

  assign op          = bus.instr[7:0];
  assign opd         = bus.instr[15:8];
  assign is_jmp      = (op == 8'hC0);
  assign is_jz       = (op == 8'hC1);
  assign is_hlt      = (op == 8'hFF);
  // JZ decides at T2 whether a T3 exists; T3 itself never looks at status again.
  assign two_step    = is_jmp | (is_jz & bus.status[ZERO_BIT]);
  assign unused_bits = ^{opd[7:5], bus.status};

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_FETCH;
      t_q    <= 4'd0;
      seen_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      t_q    <= t_nxt;
      seen_q <= seen_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    t_nxt     = t_q;
    seen_nxt  = seen_q;
    alu       = 5'd0;
    mid       = 5'd0;
    sid       = 5'd0;
    amid      = 2'd0;
    pc_inr    = 1'b0;
    mid_en    = 1'b0;
    sid_en    = 1'b0;
    amid_en   = 1'b0;

    unique case (state)
      S_FETCH: begin
        amid    = 2'd0;
        amid_en = 1'b1;
        mid     = 5'd4;
        sid     = {4'd0, t_q[0]};
        mid_en  = 1'b1;
        sid_en  = 1'b1;
        pc_inr  = 1'b1;
        if (t_q == 4'd0) begin
          t_nxt = 4'd1;
        end else begin
          state_nxt = S_EXEC;
          t_nxt     = 4'd2;
        end
      end

      S_EXEC: begin
        if (t_q == 4'd3) begin
          mid    = 5'd6;
          sid    = 5'd10;
          mid_en = 1'b1;
          sid_en = 1'b1;
        end else begin
          case (op[7:6])
            2'b00: begin
              mid    = opd[4:0];
              sid    = op[4:0];
              mid_en = 1'b1;
              sid_en = 1'b1;
            end
            2'b01: begin
              alu    = op[4:0];
              mid    = 5'd18;
              sid    = 5'd2;
              mid_en = 1'b1;
              sid_en = 1'b1;
            end
            2'b10: begin
              amid    = 2'd3;
              amid_en = 1'b1;
              mid     = op[5] ? 5'd2 : 5'd4;
              sid     = op[5] ? 5'd4 : 5'd2;
              mid_en  = 1'b1;
              sid_en  = 1'b1;
            end
            default: begin
              if (two_step) begin
                mid    = 5'd5;
                sid    = 5'd9;
                mid_en = 1'b1;
                sid_en = 1'b1;
              end
            end
          endcase
        end

        if (t_q == 4'd2 && two_step) begin
          t_nxt = 4'd3;
        end else if (bus.hlt || is_hlt) begin
          state_nxt = S_HALT;
          t_nxt     = 4'd0;
          seen_nxt  = bus.hlt;
        end else begin
          state_nxt = S_FETCH;
          t_nxt     = 4'd0;
        end
      end

      S_HALT: begin
        // Leave on the first low hlt after hlt has been seen high at least once.
        t_nxt = 4'd0;
        if (bus.hlt) begin
          seen_nxt = 1'b1;
        end else if (seen_q) begin
          state_nxt = S_FETCH;
          seen_nxt  = 1'b0;
        end
      end

      default: begin
        state_nxt = S_FETCH;
        t_nxt     = 4'd0;
        seen_nxt  = 1'b0;
      end
    endcase
  end

  always_comb begin
    cb       = '0;
    cb[20:0] = {alu, mid, sid, amid, pc_inr, mid_en, sid_en, amid_en};
  end

  assign bus.control_bus = reset ? '0 : cb;
  assign bus.T           = t_q;
  assign bus.halted      = (state == S_HALT);

endmodule
